conv3x3_window_reader: RTL and testbench

- Consumer end of the padding stage.
- Accepts one set of three padded 418-pixel rows per R/G/B channel, and streams the 416 3x3 windows of that row position, one per handshake, to the convolution datapath.
- Counts output rows and flags the end of a 416-row frame.

---
 rtl/conv3x3_window_reader_if.sv | 53 +++++
 rtl/conv3x3_window_reader.sv | 126 ++++++++++++
 tb/tb_conv3x3_window_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_window_reader_if.sv
// conv3x3_window_reader_if
//   Handshake bundle between the padding stage, the window reader and the
//   convolution datapath.
//   Row side  : row_valid/row_ready plus nine padded rows (R/G/B x rows 0..2),
//               pixel k of a row at bits [DW*k +: DW].
//   Window side: win_valid/win_ready plus R/G/B 3x3 windows, element (r,k) at
//               bits [DW*(3r+k) +: DW], window column/row indices and the
//               row_done/frame_done pulses.
//   Modports: slave  = the window reader itself,
//             master = the surrounding environment (upstream + downstream).
interface conv3x3_window_reader_if #(
    parameter int unsigned PAD_W = 418,
    parameter int unsigned DW    = 8
);
    logic                  row_valid;
    logic                  row_ready;
    logic [PAD_W*DW-1:0]   R_row0, G_row0, B_row0;
    logic [PAD_W*DW-1:0]   R_row1, G_row1, B_row1;
    logic [PAD_W*DW-1:0]   R_row2, G_row2, B_row2;
    logic                  win_valid;
    logic                  win_ready;
    logic [9*DW-1:0]       R_win, G_win, B_win;
    logic [8:0]            win_col;
    logic [8:0]            win_row;
    logic                  row_done;
    logic                  frame_done;

    modport slave (
        input  row_valid,
        input  R_row0, G_row0, B_row0,
        input  R_row1, G_row1, B_row1,
        input  R_row2, G_row2, B_row2,
        input  win_ready,
        output row_ready,
        output win_valid,
        output R_win, G_win, B_win,
        output win_col, win_row,
        output row_done, frame_done
    );

    modport master (
        output row_valid,
        output R_row0, G_row0, B_row0,
        output R_row1, G_row1, B_row1,
        output R_row2, G_row2, B_row2,
        output win_ready,
        input  row_ready,
        input  win_valid,
        input  R_win, G_win, B_win,
        input  win_col, win_row,
        input  row_done, frame_done
    );
endinterface

// File: rtl/conv3x3_window_reader.sv
// conv3x3_window_reader
//   Captures one set of three padded rows per colour channel and streams the
//   IMG_W 3x3 windows of that row position, one per win_valid/win_ready
//   handshake. Counts output rows and flags the last row of a frame.
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous active-low reset
//     en    - global enable; low freezes all state and gates the handshakes
//     bus   - row capture and window streaming handshakes (slave modport)
module conv3x3_window_reader #(
    parameter int unsigned IMG_W = 416,
    parameter int unsigned PAD_W = IMG_W + 2,
    parameter int unsigned DW    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    conv3x3_window_reader_if.slave  bus
);
    localparam logic [8:0] LAST = 9'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state_q;
    logic                rdy_q;
    logic                win_valid_q;
    logic                row_done_q;
    logic                frame_done_q;
    logic [8:0]          col_q;
    logic [8:0]          row_q;
    // [channel][row]; the current window always sits in the low three pixels
    logic [PAD_W*DW-1:0] sh_q   [3][3];
    logic [PAD_W*DW-1:0] row_in [3][3];
    logic [9*DW-1:0]     win    [3];

    assign row_in[0][0] = bus.R_row0;
    assign row_in[0][1] = bus.R_row1;
    assign row_in[0][2] = bus.R_row2;
    assign row_in[1][0] = bus.G_row0;
    assign row_in[1][1] = bus.G_row1;
    assign row_in[1][2] = bus.G_row2;
    assign row_in[2][0] = bus.B_row0;
    assign row_in[2][1] = bus.B_row1;
    assign row_in[2][2] = bus.B_row2;

    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            win[c] = '0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    win[c][DW*(3*r+k) +: DW] = sh_q[c][r][DW*k +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rdy_q        <= 1'b0;
            win_valid_q  <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            for (int unsigned c = 0; c < 3; c++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    sh_q[c][r] <= '0;
                end
            end
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    // rdy_q rises one enabled cycle after reset/DONE so that
                    // row_ready is never seen during reset itself
                    if (rdy_q && bus.row_valid) begin
                        sh_q        <= row_in;
                        col_q       <= '0;
                        win_valid_q <= 1'b1;
                        rdy_q       <= 1'b0;
                        state_q     <= STREAM;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (win_valid_q && bus.win_ready) begin
                        if (col_q == LAST) begin
                            win_valid_q  <= 1'b0;
                            row_done_q   <= 1'b1;
                            frame_done_q <= (row_q == LAST);
                            state_q      <= DONE;
                        end else begin
                            for (int unsigned c = 0; c < 3; c++) begin
                                for (int unsigned r = 0; r < 3; r++) begin
                                    sh_q[c][r] <= sh_q[c][r] >> DW;
                                end
                            end
                            col_q <= col_q + 9'd1;
                        end
                    end
                end
                DONE: begin
                    row_done_q   <= 1'b0;
                    frame_done_q <= 1'b0;
                    row_q        <= (row_q == LAST) ? '0 : row_q + 9'd1;
                    rdy_q        <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake and pulse outputs are masked while en is low; the registers
    // underneath keep their values so the stream resumes unchanged.
    assign bus.row_ready  = rdy_q & en;
    assign bus.win_valid  = win_valid_q & en;
    assign bus.row_done   = row_done_q & en;
    assign bus.frame_done = frame_done_q & en;
    assign bus.win_col    = col_q;
    assign bus.win_row    = row_q;
    assign bus.R_win      = win[0];
    assign bus.G_win      = win[1];
    assign bus.B_win      = win[2];
endmodule

// File: tb/tb_conv3x3_window_reader.sv
// tb_conv3x3_window_reader
//   Scoreboard bench: each issued row set pushes its expected windows and its
//   expected row_done into queues; a negedge monitor compares whatever the
//   window reader presents against the queue heads.
module tb_conv3x3_window_reader;
    localparam int unsigned IMG_W = 64;
    localparam int unsigned PAD_W = IMG_W + 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned VW    = PAD_W * DW;
    localparam int unsigned WW    = 9 * DW;

    logic clk = 1'b0;
    logic reset;
    logic en;
    always #5 clk = ~clk;

    conv3x3_window_reader_if #(.PAD_W(PAD_W), .DW(DW)) bus ();

    conv3x3_window_reader #(.IMG_W(IMG_W), .PAD_W(PAD_W), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    typedef struct packed {
        logic [8:0]    col;
        logic [8:0]    row;
        logic [WW-1:0] r;
        logic [WW-1:0] g;
        logic [WW-1:0] b;
    } win_t;

    typedef struct packed {
        logic [8:0] row;
        logic       frame;
    } rd_t;

    win_t       win_q[$];
    rd_t        rd_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         frames_seen = 0;
    int         exp_row = 0;
    logic [7:0] px [3][3][PAD_W];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ramp (16r+k, G=+1, B=+2); otherwise random bytes
    task automatic fill(input int mode);
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < int'(PAD_W); k++)
                    px[ch][r][k] = (mode == 0) ? 8'((16*r + k + ch) % 256) : 8'($urandom);
    endtask

    function automatic logic [VW-1:0] pack(input int ch, input int r);
        logic [VW-1:0] v;
        for (int k = 0; k < int'(PAD_W); k++) v[DW*k +: DW] = px[ch][r][k];
        return v;
    endfunction

    task automatic drive_rows();
        bus.R_row0 = pack(0, 0); bus.R_row1 = pack(0, 1); bus.R_row2 = pack(0, 2);
        bus.G_row0 = pack(1, 0); bus.G_row1 = pack(1, 1); bus.G_row2 = pack(1, 2);
        bus.B_row0 = pack(2, 0); bus.B_row1 = pack(2, 1); bus.B_row2 = pack(2, 2);
    endtask

    // Reference: window at column c is padded pixels c..c+2 of every row.
    task automatic push_expected();
        win_t e;
        rd_t  d;
        for (int c = 0; c < int'(IMG_W); c++) begin
            e.col = 9'(c);
            e.row = 9'(exp_row);
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++) begin
                    e.r[DW*(3*r+k) +: DW] = px[0][r][c+k];
                    e.g[DW*(3*r+k) +: DW] = px[1][r][c+k];
                    e.b[DW*(3*r+k) +: DW] = px[2][r][c+k];
                end
            win_q.push_back(e);
        end
        d.row   = 9'(exp_row);
        d.frame = (exp_row == int'(IMG_W) - 1);
        rd_q.push_back(d);
        exp_row = (exp_row + 1) % int'(IMG_W);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.win_valid === 1'b1) begin
                if (win_q.size() == 0) chk("spurious_window", 1, 0);
                else begin
                    chk("win_col", bus.win_col, win_q[0].col);
                    chk("win_row", bus.win_row, win_q[0].row);
                    chk("R_win", bus.R_win, win_q[0].r);
                    chk("G_win", bus.G_win, win_q[0].g);
                    chk("B_win", bus.B_win, win_q[0].b);
                    if (bus.win_ready === 1'b1) void'(win_q.pop_front());
                end
            end
            if (bus.row_done === 1'b1) begin
                if (rd_q.size() == 0) chk("spurious_row_done", 1, 0);
                else begin
                    chk("row_done_row", bus.win_row, rd_q[0].row);
                    chk("frame_done", bus.frame_done, rd_q[0].frame);
                    void'(rd_q.pop_front());
                end
                if (bus.frame_done === 1'b1) frames_seen++;
            end else if (bus.frame_done === 1'b1) begin
                chk("frame_without_row_done", 1, 0);
            end
        end
    end

    task automatic send_row(input int mode, input bit b2b, input int stall_at, input int stall_n,
                            input int en_at, input int en_n, input int rst_at);
        int  waits;
        int  cyc;
        bit  done;
        fill(mode);
        drive_rows();
        bus.row_valid = 1'b1;
        push_expected();
        waits = 0;
        while (bus.row_ready !== 1'b1 && waits < 50) begin
            step();
            waits++;
        end
        if (waits >= 50) begin
            chk("capture_timeout", 1, 0);
            return;
        end
        if (b2b) chk("b2b_gap", waits, 1);
        step();
        if (!b2b) bus.row_valid = 1'b0;
        cyc  = 1;
        done = 1'b0;
        while (cyc < 4 * int'(IMG_W)) begin
            bus.win_ready = !(cyc >= stall_at && cyc < stall_at + stall_n);
            en            = !(cyc >= en_at && cyc < en_at + en_n);
            if (cyc == 2) begin
                // new data offered mid-stream must not disturb the captured set
                fill(1);
                drive_rows();
                bus.row_valid = 1'b1;
            end
            #1;
            if (cyc == 3) chk("row_ready_in_stream", bus.row_ready, 0);
            if (!b2b && cyc == 3) bus.row_valid = 1'b0;
            if (!en) begin
                chk("win_valid_gated", bus.win_valid, 0);
                chk("row_ready_gated", bus.row_ready, 0);
            end
            if (cyc == rst_at) begin
                reset = 1'b0;
                win_q.delete();
                rd_q.delete();
                exp_row = 0;
                #1;
                chk("rst_win_valid", bus.win_valid, 0);
                chk("rst_row_ready", bus.row_ready, 0);
                chk("rst_row_done", bus.row_done, 0);
                chk("rst_win_col", bus.win_col, 0);
                chk("rst_win_row", bus.win_row, 0);
                chk("rst_R_win", bus.R_win, 0);
                step();
                step();
                bus.row_valid = 1'b0;
                reset = 1'b1;
                step();
                chk("row_ready_after_reset", bus.row_ready, 1);
                bus.win_ready = 1'b1;
                en = 1'b1;
                return;
            end
            if (bus.row_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) chk("row_done_timeout", 1, 0);
        else chk("row_latency", cyc, int'(IMG_W) + 1 + stall_n + en_n);
        bus.win_ready = 1'b1;
        en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        en            = 1'b1;
        bus.row_valid = 1'b0;
        bus.win_ready = 1'b1;
        fill(0);
        drive_rows();
        #12;
        chk("reset_row_ready", bus.row_ready, 0);
        chk("reset_win_valid", bus.win_valid, 0);
        chk("reset_win_col", bus.win_col, 0);
        chk("reset_win_row", bus.win_row, 0);
        chk("reset_row_done", bus.row_done, 0);
        chk("reset_R_win", bus.R_win, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("row_ready_after_release", bus.row_ready, 1);

        send_row(0, 1'b0, 0, 0, 0, 0, 0);      // ramp, free-running
        send_row(1, 1'b0, 5, 5, 0, 0, 0);      // backpressure cycles 5..9
        send_row(1, 1'b0, 0, 0, 20, 3, 0);     // en low for 3 cycles
        send_row(1, 1'b0, 0, 0, 0, 0, 41);     // reset at col 40
        for (int i = 0; i <= int'(IMG_W); i++)
            send_row(1, i > 0, 0, 0, 0, 0, 0); // full frame plus one wrap row
        bus.row_valid = 1'b0;
        repeat (4) step();
        chk("frame_done_count", frames_seen, 1);
        chk("queues_drained", win_q.size() + rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
